rom_loader: RTL



---
 rtl/rom_loader.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader: clears ERASE_WORDS RAM words, then writes host ROM halfwords at ROM_BASE over Wishbone.
// One write in flight at a time; dl_wait stalls the host. Define ROM_LOADER_PACK_EN to pair halfwords into words.
module rom_loader #(
  parameter int unsigned ERASE_WORDS = 1048576,
  parameter logic [23:0] ROM_BASE    = 24'h100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [15:0] dl_data,
  output logic        dl_wait,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [23:0] wb_adr,
  output logic [31:0] wb_dat,
  input  logic        wb_ack,
  output logic        host_owns,
  output logic        done
);

`ifdef ROM_LOADER_PACK_EN
  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_LOAD, S_FLUSH, S_ABORT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_LOAD, S_ABORT} state_t;
`endif

  localparam logic [23:0] ERASE_LAST = 24'(ERASE_WORDS - 1);

  state_t      state, state_nxt;
  logic        act_q;
  logic        act_rise, act_fall;
  logic        bus_q, bus_nxt;
  logic [23:0] erase_addr, erase_addr_nxt;
  logic [3:0]  sel_nxt;
  logic [23:0] adr_nxt;
  logic [31:0] dat_nxt;
  logic        wait_nxt, done_nxt;
  logic [19:0] hw_word;
  logic [23:0] hw_adr;
  logic        unused_addr_bits;

`ifdef ROM_LOADER_PACK_EN
  logic        pend_lo, pend_lo_nxt;
  logic [15:0] buf_dat, buf_dat_nxt;
  logic [19:0] buf_word, buf_word_nxt;
  logic [23:0] buf_adr;
  assign buf_adr = ROM_BASE + {4'b0, buf_word};
`endif

  // Upper address bits are dropped so the ROM image wraps inside 4 MB.
  assign hw_word          = dl_addr[21:2];
  assign hw_adr           = ROM_BASE + {4'b0, hw_word};
  assign unused_addr_bits = ^{dl_addr[24:22], dl_addr[0]};

  assign act_rise  = dl_active & ~act_q;
  assign act_fall  = ~dl_active & act_q;
  assign wb_cyc    = bus_q;
  assign wb_stb    = bus_q;
  assign wb_we     = 1'b1;
  assign host_owns = (state != S_IDLE);

  always_comb begin
    state_nxt      = state;
    erase_addr_nxt = erase_addr;
    bus_nxt        = bus_q;
    sel_nxt        = wb_sel;
    adr_nxt        = wb_adr;
    dat_nxt        = wb_dat;
    wait_nxt       = dl_wait;
    done_nxt       = 1'b0;
`ifdef ROM_LOADER_PACK_EN
    pend_lo_nxt    = pend_lo;
    buf_dat_nxt    = buf_dat;
    buf_word_nxt   = buf_word;
`endif
    case (state)
      S_IDLE: begin
        if (act_rise) begin
          state_nxt      = S_ERASE;
          erase_addr_nxt = '0;
          bus_nxt        = 1'b1;
          sel_nxt        = 4'hF;
          adr_nxt        = '0;
          dat_nxt        = '0;
          wait_nxt       = 1'b1;
        end
      end
      S_ERASE: begin
        if (act_fall) begin
          // An ack landing with the fall leaves nothing outstanding to wait for.
          if (wb_ack) begin
            state_nxt = S_IDLE;
            bus_nxt   = 1'b0;
            wait_nxt  = 1'b0;
          end else begin
            state_nxt = S_ABORT;
          end
        end else if (wb_ack) begin
          if (erase_addr == ERASE_LAST) begin
            state_nxt = S_LOAD;
            bus_nxt   = 1'b0;
            wait_nxt  = 1'b0;
          end else begin
            erase_addr_nxt = erase_addr + 24'd1;
            adr_nxt        = erase_addr + 24'd1;
          end
        end
      end
      S_LOAD: begin
        if (dl_wait) begin
          if (wb_ack) begin
            bus_nxt  = 1'b0;
            wait_nxt = 1'b0;
          end
        end else if (!dl_active) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
`ifdef ROM_LOADER_PACK_EN
          if (pend_lo) begin
            state_nxt   = S_FLUSH;
            done_nxt    = 1'b0;
            bus_nxt     = 1'b1;
            wait_nxt    = 1'b1;
            adr_nxt     = buf_adr;
            sel_nxt     = 4'h3;
            dat_nxt     = {buf_dat, buf_dat};
            pend_lo_nxt = 1'b0;
          end
`endif
        end else if (dl_wr) begin
`ifdef ROM_LOADER_PACK_EN
          if (dl_addr[1]) begin
            bus_nxt  = 1'b1;
            wait_nxt = 1'b1;
            adr_nxt  = hw_adr;
            if (pend_lo && (buf_word == hw_word)) begin
              sel_nxt     = 4'hF;
              dat_nxt     = {dl_data, buf_dat};
              pend_lo_nxt = 1'b0;
            end else begin
              sel_nxt = 4'hC;
              dat_nxt = {dl_data, dl_data};
            end
          end else begin
            // The old low half goes out from the bus registers, so the buffer is free at once.
            if (pend_lo) begin
              bus_nxt  = 1'b1;
              wait_nxt = 1'b1;
              adr_nxt  = buf_adr;
              sel_nxt  = 4'h3;
              dat_nxt  = {buf_dat, buf_dat};
            end
            pend_lo_nxt  = 1'b1;
            buf_dat_nxt  = dl_data;
            buf_word_nxt = hw_word;
          end
`else
          bus_nxt  = 1'b1;
          wait_nxt = 1'b1;
          adr_nxt  = hw_adr;
          sel_nxt  = dl_addr[1] ? 4'hC : 4'h3;
          dat_nxt  = {dl_data, dl_data};
`endif
        end
      end
`ifdef ROM_LOADER_PACK_EN
      S_FLUSH: begin
        if (wb_ack) begin
          state_nxt = S_IDLE;
          bus_nxt   = 1'b0;
          wait_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
`endif
      S_ABORT: begin
        if (wb_ack) begin
          state_nxt = S_IDLE;
          bus_nxt   = 1'b0;
          wait_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        bus_nxt   = 1'b0;
        wait_nxt  = 1'b0;
      end
    endcase
    if (!bus_nxt) begin
      sel_nxt = '0;
      adr_nxt = '0;
      dat_nxt = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      act_q      <= 1'b0;
      bus_q      <= 1'b0;
      erase_addr <= '0;
      wb_sel     <= '0;
      wb_adr     <= '0;
      wb_dat     <= '0;
      dl_wait    <= 1'b0;
      done       <= 1'b0;
`ifdef ROM_LOADER_PACK_EN
      pend_lo    <= 1'b0;
      buf_dat    <= '0;
      buf_word   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      act_q      <= dl_active;
      bus_q      <= bus_nxt;
      erase_addr <= erase_addr_nxt;
      wb_sel     <= sel_nxt;
      wb_adr     <= adr_nxt;
      wb_dat     <= dat_nxt;
      dl_wait    <= wait_nxt;
      done       <= done_nxt;
`ifdef ROM_LOADER_PACK_EN
      pend_lo    <= pend_lo_nxt;
      buf_dat    <= buf_dat_nxt;
      buf_word   <= buf_word_nxt;
`endif
    end
  end

endmodule
